// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: programmable LED bank sequencer.
//
// A host loads mode/period/steps over a valid/ready handshake while idle, then
// starts a run. During a run a prescaler generates a tick every period+1 cycles,
// and each tick advances the LED pattern according to the mode. A non-zero step
// count ends the run automatically; stop_i aborts it.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   cfg_valid_i    configuration offered
//   cfg_ready_o    configuration accepted (high whenever idle)
//   cfg_mode_i     0 count up, 1 rotate left, 2 toggle all, 3 hold
//   cfg_period_i   tick interval minus one, in cycles
//   cfg_steps_i    ticks per run, 0 = run until stop
//   start_i        begin a run (level)
//   stop_i         abort a run
//   busy_o         high while running
//   done_o         one-cycle pulse after normal completion
//   led_o          registered LED pattern
module led_blink_scheduler #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned PRESCALE_WIDTH = 32,
    parameter int unsigned STEP_WIDTH     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [1:0]                cfg_mode_i,
    input  logic [PRESCALE_WIDTH-1:0] cfg_period_i,
    input  logic [STEP_WIDTH-1:0]     cfg_steps_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [WIDTH-1:0]          led_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModeCount  = 2'd0;
    localparam logic [1:0] ModeRotate = 2'd1;
    localparam logic [1:0] ModeToggle = 2'd2;

    localparam logic [PRESCALE_WIDTH-1:0] PeriodDefault = PRESCALE_WIDTH'(1023);

    state_e                    state_q, state_d;
    logic [1:0]                mode_q, mode_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [STEP_WIDTH-1:0]     steps_q, steps_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [STEP_WIDTH-1:0]     scnt_q, scnt_d;
    logic [WIDTH-1:0]          led_q, led_d;
    logic                      done_q, done_d;

    logic                      tick;
    logic [STEP_WIDTH-1:0]     scnt_inc;
    logic [WIDTH-1:0]          led_ticked;

    assign cfg_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q == StRun);
    assign done_o      = done_q;
    assign led_o       = led_q;

    assign tick     = (pcnt_q == period_q);
    assign scnt_inc = scnt_q + STEP_WIDTH'(1);

    // Pattern after one tick in the current mode.
    always_comb begin
        led_ticked = led_q;
        unique case (mode_q)
            ModeCount:  led_ticked = led_q + WIDTH'(1);
            ModeRotate: led_ticked = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            ModeToggle: led_ticked = ~led_q;
            default:    led_ticked = led_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        steps_d  = steps_q;
        pcnt_d   = pcnt_q;
        scnt_d   = scnt_q;
        led_d    = led_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A handshake takes priority over start in the same cycle.
                if (cfg_valid_i) begin
                    mode_d   = cfg_mode_i;
                    period_d = cfg_period_i;
                    steps_d  = cfg_steps_i;
                    unique case (cfg_mode_i)
                        ModeCount:  led_d = '0;
                        ModeRotate: led_d = WIDTH'(1);
                        ModeToggle: led_d = '0;
                        default:    led_d = led_q;
                    endcase
                end else if (start_i) begin
                    state_d = StRun;
                    pcnt_d  = '0;
                    scnt_d  = '0;
                end
            end
            StRun: begin
                // Stop wins over a tick landing on the same edge.
                if (stop_i) begin
                    state_d = StIdle;
                end else if (tick) begin
                    pcnt_d = '0;
                    scnt_d = scnt_inc;
                    led_d  = led_ticked;
                    if ((steps_q != '0) && (scnt_inc == steps_q)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            mode_q   <= ModeCount;
            period_q <= PeriodDefault;
            steps_q  <= '0;
            pcnt_q   <= '0;
            scnt_q   <= '0;
            led_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            steps_q  <= steps_d;
            pcnt_q   <= pcnt_d;
            scnt_q   <= scnt_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

endmodule
